// File: rtl/legv8_pkg.sv
// -----------------------------------------------------------------------------
// legv8_pkg
// Shared types and constants for the multicycle LEGv8 controller:
//   state_t     - controller sequencing states
//   op_class_t  - instruction class produced by the opcode decoder
//   OP_*        - 11-bit opcode field values (and masks for CBZ/B, whose
//                 low opcode bits belong to the immediate)
//   ALU_*       - AluControl encodings understood by the execute stage
//   op_match()  - masked opcode comparison helper
// -----------------------------------------------------------------------------
package legv8_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_LD      = 3'd1,
        CLS_ST      = 3'd2,
        CLS_CBZ     = 3'd3,
        CLS_B       = 3'd4,
        CLS_ILLEGAL = 3'd5
    } op_class_t;

    localparam logic [10:0] OP_ADD      = 11'b10001011000;
    localparam logic [10:0] OP_SUB      = 11'b11001011000;
    localparam logic [10:0] OP_AND      = 11'b10001010000;
    localparam logic [10:0] OP_ORR      = 11'b10101010000;
    localparam logic [10:0] OP_LDUR     = 11'b11111000010;
    localparam logic [10:0] OP_STUR     = 11'b11111000000;
    localparam logic [10:0] OP_CBZ      = 11'b10110100000;
    localparam logic [10:0] OP_CBZ_MASK = 11'b11111111000;
    localparam logic [10:0] OP_B        = 11'b00010100000;
    localparam logic [10:0] OP_B_MASK   = 11'b11111100000;
    localparam logic [10:0] OP_FULL     = 11'b11111111111;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_ORR  = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_PASS = 4'b0111;

    // True when the opcode bits selected by mask equal the reference value.
    function automatic logic op_match(input logic [10:0] op,
                                      input logic [10:0] ref_val,
                                      input logic [10:0] mask);
        return ((op & mask) == (ref_val & mask));
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
// Decodes the latched 11-bit opcode into the execute-stage controls and an
// instruction class used by the sequencing FSM.
//   opcode       in   11  latched opcode field
//   alu_control  out  4   AluControl value to present during EXEC
//   alu_src      out  1   0: readData2, 1: signImm
//   op_class     out  3   rtype / ld / st / cbz / b / illegal
// -----------------------------------------------------------------------------
module alu_decoder
    import legv8_pkg::*;
(
    input  logic [10:0] opcode,
    output logic [3:0]  alu_control,
    output logic        alu_src,
    output op_class_t   op_class
);

    // Opcode classification and ALU control lookup.
    always_comb begin
        alu_control = ALU_AND;
        alu_src     = 1'b0;
        op_class    = CLS_ILLEGAL;
        if (op_match(opcode, OP_ADD, OP_FULL)) begin
            op_class    = CLS_RTYPE;
            alu_control = ALU_ADD;
        end else if (op_match(opcode, OP_SUB, OP_FULL)) begin
            op_class    = CLS_RTYPE;
            alu_control = ALU_SUB;
        end else if (op_match(opcode, OP_AND, OP_FULL)) begin
            op_class    = CLS_RTYPE;
            alu_control = ALU_AND;
        end else if (op_match(opcode, OP_ORR, OP_FULL)) begin
            op_class    = CLS_RTYPE;
            alu_control = ALU_ORR;
        end else if (op_match(opcode, OP_LDUR, OP_FULL)) begin
            op_class    = CLS_LD;
            alu_control = ALU_ADD;
            alu_src     = 1'b1;
        end else if (op_match(opcode, OP_STUR, OP_FULL)) begin
            op_class    = CLS_ST;
            alu_control = ALU_ADD;
            alu_src     = 1'b1;
        end else if (op_match(opcode, OP_CBZ, OP_CBZ_MASK)) begin
            // CBZ tests Rt, which arrives on the B operand: pass it through.
            op_class    = CLS_CBZ;
            alu_control = ALU_PASS;
        end else if (op_match(opcode, OP_B, OP_B_MASK)) begin
            op_class    = CLS_B;
        end else begin
            op_class    = CLS_ILLEGAL;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Sequencing controller for a shared-datapath multicycle LEGv8 core:
// FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, with a ready handshake
// (and timeout) on instruction and data memory, and a retired-instruction
// counter. Illegal opcodes and memory timeouts park the FSM in HALT until reset.
//   clk          in   1        clock, rising edge
//   reset        in   1        asynchronous active-high reset
//   instr        in   11       opcode field of the instruction word
//   imem_ready   in   1        instruction word valid this cycle
//   dmem_ready   in   1        data access complete this cycle
//   zero         in   1        zero flag from the execute stage
//   irWrite      out  1        IR load enable
//   pcWrite      out  1        PC load enable
//   pcSrc        out  1        0: PC+4, 1: PCBranch
//   AluSrc       out  1        0: readData2, 1: signImm
//   AluControl   out  4        ALU operation
//   memRead      out  1        imem read (FETCH) / dmem read (MEM)
//   memWrite     out  1        dmem write
//   regWrite     out  1        register-file write
//   memtoReg     out  1        WB source: 1 memory, 0 ALU
//   halted       out  1        sticky halt indication
//   instr_count  out  COUNT_W  retired-instruction count (wrapping)
// -----------------------------------------------------------------------------
module multicycle_ctrl
    import legv8_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int COUNT_W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [10:0]        instr,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    input  logic               zero,
    output logic               irWrite,
    output logic               pcWrite,
    output logic               pcSrc,
    output logic               AluSrc,
    output logic [3:0]         AluControl,
    output logic               memRead,
    output logic               memWrite,
    output logic               regWrite,
    output logic               memtoReg,
    output logic               halted,
    output logic [COUNT_W-1:0] instr_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t             state_r;
    state_t             state_next_s;
    logic [10:0]        opcode_r;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic [COUNT_W-1:0] instr_count_r;
    logic [3:0]         dec_alu_control_s;
    logic               dec_alu_src_s;
    op_class_t          dec_class_s;
    logic               last_wait_s;
    logic               waiting_s;
    logic               retire_s;

    alu_decoder u_alu_decoder (
        .opcode      (opcode_r),
        .alu_control (dec_alu_control_s),
        .alu_src     (dec_alu_src_s),
        .op_class    (dec_class_s)
    );

    // This low-ready cycle is the one that would take the counter to the limit;
    // a ready on this cycle still wins because ready is tested first below.
    assign last_wait_s = (wait_cnt_r == WAIT_W'(MEM_TIMEOUT - 1));

    // Next-state selection.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            FETCH: begin
                if (imem_ready) begin
                    state_next_s = DECODE;
                end else if (last_wait_s) begin
                    state_next_s = HALT;
                end else begin
                    state_next_s = FETCH;
                end
            end
            DECODE: begin
                if (dec_class_s == CLS_ILLEGAL) begin
                    state_next_s = HALT;
                end else begin
                    state_next_s = EXEC;
                end
            end
            EXEC: begin
                case (dec_class_s)
                    CLS_RTYPE:      state_next_s = WB;
                    CLS_LD, CLS_ST: state_next_s = MEM;
                    CLS_CBZ, CLS_B: state_next_s = FETCH;
                    default:        state_next_s = HALT;
                endcase
            end
            MEM: begin
                if (dmem_ready) begin
                    if (dec_class_s == CLS_LD) begin
                        state_next_s = WB;
                    end else begin
                        state_next_s = FETCH;
                    end
                end else if (last_wait_s) begin
                    state_next_s = HALT;
                end else begin
                    state_next_s = MEM;
                end
            end
            WB:      state_next_s = FETCH;
            HALT:    state_next_s = HALT;
            default: state_next_s = HALT;
        endcase
    end

    // An instruction retires on the cycle its last state hands back to FETCH.
    assign retire_s = (state_r != FETCH) && (state_r != HALT) && (state_next_s == FETCH);

    // A cycle that counts against the memory timeout.
    assign waiting_s = ((state_r == FETCH) && !imem_ready) || ((state_r == MEM) && !dmem_ready);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Opcode register, loaded together with the IR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opcode_r <= 11'd0;
        end else if ((state_r == FETCH) && imem_ready) begin
            opcode_r <= instr;
        end else begin
            opcode_r <= opcode_r;
        end
    end

    // Memory wait counter: cleared on any state change, counts stalled cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= '0;
        end else if (state_next_s != state_r) begin
            wait_cnt_r <= '0;
        end else if (waiting_s) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Retired-instruction counter; naturally wraps and is frozen in HALT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_count_r <= '0;
        end else if (retire_s) begin
            instr_count_r <= instr_count_r + COUNT_W'(1);
        end else begin
            instr_count_r <= instr_count_r;
        end
    end

    assign instr_count = instr_count_r;

    // Output decode from state and latched opcode; reset forces every enable low.
    always_comb begin
        irWrite    = 1'b0;
        pcWrite    = 1'b0;
        pcSrc      = 1'b0;
        AluSrc     = 1'b0;
        AluControl = ALU_AND;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        regWrite   = 1'b0;
        memtoReg   = 1'b0;
        halted     = 1'b0;
        if (reset) begin
            halted = 1'b0;
        end else begin
            case (state_r)
                FETCH: begin
                    memRead = 1'b1;
                    if (imem_ready) begin
                        irWrite = 1'b1;
                        pcWrite = 1'b1;
                        pcSrc   = 1'b0;
                    end else begin
                        irWrite = 1'b0;
                    end
                end
                DECODE: begin
                    halted = 1'b0;
                end
                EXEC: begin
                    AluSrc     = dec_alu_src_s;
                    AluControl = dec_alu_control_s;
                    case (dec_class_s)
                        CLS_CBZ: begin
                            pcSrc   = 1'b1;
                            pcWrite = zero;
                        end
                        CLS_B: begin
                            pcSrc   = 1'b1;
                            pcWrite = 1'b1;
                        end
                        default: pcSrc = 1'b0;
                    endcase
                end
                MEM: begin
                    // Held for the whole access until dmem_ready.
                    memRead  = (dec_class_s == CLS_LD);
                    memWrite = (dec_class_s == CLS_ST);
                end
                WB: begin
                    regWrite = 1'b1;
                    memtoReg = (dec_class_s == CLS_LD);
                end
                HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    halted = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Scoreboard bench: the stimulus process expands each instruction into the
// cycle-by-cycle output pattern it should produce and queues it; a monitor on
// the falling edge pops one entry per cycle and compares against the DUT.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam int TO = 16;

    // Output vector layout: {irWrite,pcWrite,pcSrc,AluSrc,AluControl[3:0],
    //                        memRead,memWrite,regWrite,memtoReg,halted}
    localparam logic [12:0] B_IR   = 13'h1000;
    localparam logic [12:0] B_PCW  = 13'h0800;
    localparam logic [12:0] B_PCS  = 13'h0400;
    localparam logic [12:0] B_ASRC = 13'h0200;
    localparam logic [12:0] M_ALU  = 13'h01E0;
    localparam logic [12:0] B_MRD  = 13'h0010;
    localparam logic [12:0] B_MWR  = 13'h0008;
    localparam logic [12:0] B_RW   = 13'h0004;
    localparam logic [12:0] B_M2R  = 13'h0002;
    localparam logic [12:0] B_HLT  = 13'h0001;
    localparam logic [12:0] BASE_M = B_IR | B_PCW | B_MRD | B_MWR | B_RW | B_HLT;

    localparam logic [10:0] T_ADD  = 11'b10001011000;
    localparam logic [10:0] T_SUB  = 11'b11001011000;
    localparam logic [10:0] T_AND  = 11'b10001010000;
    localparam logic [10:0] T_ORR  = 11'b10101010000;
    localparam logic [10:0] T_LDUR = 11'b11111000010;
    localparam logic [10:0] T_STUR = 11'b11111000000;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] instr;
    logic        imem_ready, dmem_ready, zero;
    logic        irWrite, pcWrite, pcSrc, AluSrc, memRead, memWrite, regWrite, memtoReg, halted;
    logic [3:0]  AluControl;
    logic [31:0] instr_count;

    multicycle_ctrl #(.MEM_TIMEOUT(TO), .COUNT_W(32)) dut (
        .clk(clk), .reset(reset), .instr(instr),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .zero(zero),
        .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc), .AluSrc(AluSrc),
        .AluControl(AluControl), .memRead(memRead), .memWrite(memWrite),
        .regWrite(regWrite), .memtoReg(memtoReg), .halted(halted),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] v;
        logic [12:0] m;
        logic [31:0] cnt;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] model_count = 32'd0;

    function automatic logic rb();
        return ($urandom_range(1, 0) == 1);
    endfunction

    function automatic exp_t mk(input string nm, input logic [12:0] v, input logic [12:0] extra_m);
        exp_t e;
        e.v    = v;
        e.m    = BASE_M | extra_m;
        e.cnt  = model_count;
        e.name = nm;
        return e;
    endfunction

    function automatic logic [12:0] alu_field(input logic [3:0] code);
        return {4'b0000, code, 5'b00000};
    endfunction

    // Instruction class from the opcode rules: 0 R, 1 LDUR, 2 STUR, 3 CBZ, 4 B, 5 illegal.
    function automatic int cls_of(input logic [10:0] op);
        logic [7:0] hi8;
        logic [5:0] hi6;
        hi8 = op[10:3];
        hi6 = op[10:5];
        if (op == T_ADD || op == T_SUB || op == T_AND || op == T_ORR) return 0;
        if (op == T_LDUR) return 1;
        if (op == T_STUR) return 2;
        if (hi8 == 8'b10110100) return 3;
        if (hi6 == 6'b000101) return 4;
        return 5;
    endfunction

    function automatic logic [3:0] r_alu(input logic [10:0] op);
        if (op == T_ADD) return 4'b0010;
        if (op == T_SUB) return 4'b0110;
        if (op == T_AND) return 4'b0000;
        return 4'b0001;
    endfunction

    // Monitor: one expected entry per clock cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [12:0] act;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {irWrite, pcWrite, pcSrc, AluSrc, AluControl, memRead, memWrite,
                   regWrite, memtoReg, halted};
            total++;
            if ((((act ^ e.v) & e.m) !== 13'd0) || (instr_count !== e.cnt)) begin
                bad++;
                $display("FAIL %s: got outputs=%b count=%0d, want outputs=%b (mask %b) count=%0d",
                         e.name, act, instr_count, e.v, e.m, e.cnt);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, expv);
        end
    endtask

    task automatic step(input logic im, input logic dm, input logic z, input exp_t e);
        imem_ready = im;
        dmem_ready = dm;
        zero       = z;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic halt_cycles(input string nm, input int n);
        for (int i = 0; i < n; i++) begin
            instr = 11'($urandom);
            step(rb(), rb(), rb(), mk({nm, ".halt"}, B_HLT, 13'd0));
        end
    endtask

    task automatic do_reset(input int n);
        reset       = 1'b1;
        model_count = 32'd0;
        for (int i = 0; i < n; i++) begin
            step(rb(), rb(), rb(), mk("reset", 13'd0, 13'd0) );
            sb[sb.size() - 1].m = BASE_M & ~B_MRD;
        end
        reset = 1'b0;
    endtask

    // Expand one instruction into its expected cycle sequence.
    task automatic run_instr(input logic [10:0] op, input int iw, input int dw,
                             input logic z, input string nm);
        int          c;
        logic [12:0] mem_en;
        c     = cls_of(op);
        instr = op;
        for (int i = 0; i < iw && i < TO; i++)
            step(1'b0, rb(), rb(), mk({nm, ".fwait"}, B_MRD, 13'd0));
        if (iw >= TO) begin
            halt_cycles(nm, 4);
            return;
        end
        step(1'b1, rb(), rb(), mk({nm, ".fetch"}, B_IR | B_PCW | B_MRD, B_PCS));
        step(rb(), rb(), rb(), mk({nm, ".decode"}, 13'd0, 13'd0));
        if (c == 5) begin
            halt_cycles(nm, 6);
            return;
        end
        case (c)
            0: begin
                step(rb(), rb(), rb(), mk({nm, ".exec"}, alu_field(r_alu(op)), B_ASRC | M_ALU));
                step(rb(), rb(), rb(), mk({nm, ".wb"}, B_RW, B_M2R));
                model_count++;
            end
            1, 2: begin
                step(rb(), rb(), rb(), mk({nm, ".exec"}, B_ASRC | alu_field(4'b0010), B_ASRC | M_ALU));
                mem_en = (c == 1) ? B_MRD : B_MWR;
                for (int i = 0; i < dw && i < TO; i++)
                    step(rb(), 1'b0, rb(), mk({nm, ".mwait"}, mem_en, 13'd0));
                if (dw >= TO) begin
                    halt_cycles(nm, 4);
                    return;
                end
                step(rb(), 1'b1, rb(), mk({nm, ".mem"}, mem_en, 13'd0));
                if (c == 1) begin
                    step(rb(), rb(), rb(), mk({nm, ".wb"}, B_RW | B_M2R, B_M2R));
                end
                model_count++;
            end
            3: begin
                step(rb(), rb(), z, mk({nm, ".exec"}, B_PCS | (z ? B_PCW : 13'd0) | alu_field(4'b0111),
                                       B_PCS | B_ASRC | M_ALU));
                model_count++;
            end
            default: begin
                step(rb(), rb(), rb(), mk({nm, ".exec"}, B_PCS | B_PCW, B_PCS));
                model_count++;
            end
        endcase
    endtask

    initial begin
        logic [10:0] ops[8];
        logic [10:0] op;
        reset      = 1'b1;
        instr      = 11'd0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        zero       = 1'b0;
        @(posedge clk);
        #1;
        do_reset(2);

        // Directed cases
        run_instr(T_ADD, 0, 0, 1'b0, "add");
        run_instr(T_LDUR, 0, 3, 1'b0, "ldur_w3");
        run_instr(11'b10110100101, 0, 0, 1'b1, "cbz_taken");
        run_instr(11'b10110100010, 0, 0, 1'b0, "cbz_not");
        run_instr(T_STUR, 0, 0, 1'b0, "stur");
        run_instr(11'b00010111011, 0, 0, 1'b0, "b");
        run_instr(T_SUB, 2, 0, 1'b0, "sub");
        run_instr(T_AND, 1, 0, 1'b0, "and");
        run_instr(T_ORR, 3, 0, 1'b0, "orr");

        // Randomized legal instruction stream
        ops[0] = T_ADD;  ops[1] = T_SUB;  ops[2] = T_AND;  ops[3] = T_ORR;
        ops[4] = T_LDUR; ops[5] = T_STUR; ops[6] = 11'b10110100000; ops[7] = 11'b00010100000;
        for (int k = 0; k < 40; k++) begin
            op = ops[$urandom_range(7, 0)];
            if (op == 11'b10110100000) op[2:0] = 3'($urandom);
            if (op == 11'b00010100000) op[4:0] = 5'($urandom);
            run_instr(op, $urandom_range(4, 0), $urandom_range(4, 0), rb(), "rand");
        end

        // Ready arriving on the last permitted cycle wins
        run_instr(T_ADD, TO - 1, 0, 1'b0, "imem_edge");
        run_instr(T_LDUR, 0, TO - 1, 1'b0, "dmem_edge_ld");
        run_instr(T_STUR, 0, TO - 1, 1'b0, "dmem_edge_st");

        // Illegal opcode halts with count frozen
        run_instr(11'b11111111111, 0, 0, 1'b0, "illegal");
        do_reset(2);

        // Instruction-memory timeout
        run_instr(T_ADD, 0, 0, 1'b0, "pre_to");
        run_instr(T_ADD, TO, 0, 1'b0, "imem_to");
        do_reset(2);

        // Data-memory timeout
        run_instr(T_STUR, 0, TO, 1'b0, "dmem_to");
        do_reset(2);

        // Reset asserted mid-MEM of a STUR
        run_instr(T_ADD, 0, 0, 1'b0, "pre_rst");
        instr = T_STUR;
        step(1'b1, 1'b0, 1'b0, mk("rst_st.fetch", B_IR | B_PCW | B_MRD, B_PCS));
        step(1'b0, 1'b0, 1'b0, mk("rst_st.decode", 13'd0, 13'd0));
        step(1'b0, 1'b0, 1'b0, mk("rst_st.exec", B_ASRC | alu_field(4'b0010), B_ASRC | M_ALU));
        step(1'b0, 1'b0, 1'b0, mk("rst_st.mwait", B_MWR, 13'd0));
        dmem_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_st.mwr_before", 32'(memWrite), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_st.mwr_after", 32'(memWrite), 32'd0);
        chk("rst_st.count", instr_count, 32'd0);
        @(posedge clk);
        #1;
        do_reset(1);
        run_instr(T_ADD, 0, 0, 1'b0, "post_rst");

        @(negedge clk);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
